// File: rtl/ctrl_stall_unit.sv
// ctrl_stall_unit: central pipeline stall arbiter with watchdog.
// Generates the 6-bit stall vector (bit0 PC .. bit5 WB) from ID/EX/MEM
// stall requests with priority mem > ex > id. It also tracks the
// consecutive stall length and raises a sticky watchdog error when the
// pipeline stays frozen for WDOG_LIMIT cycles.
// Optional feature macro: CTRL_PERF_CNT_EN adds free-running 32-bit
// stall_cycles / mem_stall_cycles performance counters.
module ctrl_stall_unit #(
  parameter int unsigned WDOG_LIMIT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_from_id,
  input  logic        stallreq_from_ex,
  input  logic        stallreq_from_mem,
  input  logic        wdog_clr,
  output logic [5:0]  stall,
  output logic [1:0]  stall_src,
  output logic [15:0] stall_run_len,
  output logic        wdog_err
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] mem_stall_cycles
`endif
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    STALLING = 2'd1,
    HUNG     = 2'd2
  } state_t;

  localparam logic [15:0] WDOG_LIMIT_C = 16'(WDOG_LIMIT);

  // Saturating 16-bit increment; the run length parks at all-ones.
  function automatic logic [15:0] sat_inc16(input logic [15:0] val);
    if (val == 16'hFFFF) begin
      sat_inc16 = 16'hFFFF;
    end else begin
      sat_inc16 = val + 16'd1;
    end
  endfunction

  state_t      state_r;
  state_t      state_next_s;
  logic [15:0] run_len_r;
  logic [15:0] run_len_next_s;
  logic        wdog_err_r;
  logic        req_s;
  logic [5:0]  stall_s;
  logic [1:0]  stall_src_s;

  assign req_s = stallreq_from_id | stallreq_from_ex | stallreq_from_mem;

  // Zero-latency priority decode of the stall vector; held quiet during reset.
  always_comb begin
    stall_s     = 6'b000000;
    stall_src_s = 2'd0;
    if (rst) begin
      stall_s     = 6'b000000;
      stall_src_s = 2'd0;
    end else if (stallreq_from_mem) begin
      stall_s     = 6'b011111;
      stall_src_s = 2'd3;
    end else if (stallreq_from_ex) begin
      stall_s     = 6'b001111;
      stall_src_s = 2'd2;
    end else if (stallreq_from_id) begin
      stall_s     = 6'b000111;
      stall_src_s = 2'd1;
    end else begin
      stall_s     = 6'b000000;
      stall_src_s = 2'd0;
    end
  end

  // Next run length: clears on an idle edge, restarts at 1 when a hung
  // watchdog is cleared under an active request, otherwise counts up.
  always_comb begin
    run_len_next_s = 16'd0;
    if (!req_s) begin
      run_len_next_s = 16'd0;
    end else if ((state_r == HUNG) && wdog_clr) begin
      run_len_next_s = 16'd1;
    end else begin
      run_len_next_s = sat_inc16(run_len_r);
    end
  end

  // Watchdog state machine next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (req_s) begin
          state_next_s = STALLING;
        end else begin
          state_next_s = IDLE;
        end
      end
      STALLING: begin
        if (!req_s) begin
          state_next_s = IDLE;
        end else if (run_len_next_s == WDOG_LIMIT_C) begin
          state_next_s = HUNG;
        end else begin
          state_next_s = STALLING;
        end
      end
      HUNG: begin
        if (wdog_clr) begin
          if (req_s) begin
            state_next_s = STALLING;
          end else begin
            state_next_s = IDLE;
          end
        end else begin
          state_next_s = HUNG;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State, run length and error flag registers; error mirrors the HUNG state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      run_len_r  <= 16'd0;
      wdog_err_r <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      run_len_r  <= run_len_next_s;
      wdog_err_r <= (state_next_s == HUNG);
    end
  end

  assign stall         = stall_s;
  assign stall_src     = stall_src_s;
  assign stall_run_len = run_len_r;
  assign wdog_err      = wdog_err_r;

`ifdef CTRL_PERF_CNT_EN
  logic [31:0] stall_cycles_r;
  logic [31:0] mem_stall_cycles_r;

  // Free-running performance counters, wrapping modulo 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles_r     <= 32'd0;
      mem_stall_cycles_r <= 32'd0;
    end else begin
      if (req_s) begin
        stall_cycles_r <= stall_cycles_r + 32'd1;
      end else begin
        stall_cycles_r <= stall_cycles_r;
      end
      if (stallreq_from_mem) begin
        mem_stall_cycles_r <= mem_stall_cycles_r + 32'd1;
      end else begin
        mem_stall_cycles_r <= mem_stall_cycles_r;
      end
    end
  end

  assign stall_cycles     = stall_cycles_r;
  assign mem_stall_cycles = mem_stall_cycles_r;
`endif

endmodule
